charge_injection_pulse_checker: RTL
===================================

Name: charge_injection_pulse_checker

Overview:
- Receive-side checker for the charge-injection path. Runs on clk1280 and watches the chargeInjectionCmd strobe and the resulting injection pulse.
- For each command it measures the pulse delay in clk1280 steps and the pulse width, compares the delay with the programmed 5-bit delay, and keeps error counters.
- Used in-chip as a self-test monitor next to the pulse generator, and in benches as the decode end of the command-to-pulse path.

Parameters:
- OFFSET, 4, fixed clk1280 latency from command edge to a delay-0 pulse edge; subtracted from the raw count.
- TIMEOUT, 127, maximum clk1280 cycles allowed in WAIT_PULSE, and separately in MEAS_WIDTH, before aborting.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk1280  in  1  1.28 GHz clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- chargeInjectionCmd  in  1  command level from the clk40 domain, high for 32 clk1280 cycles.
- pulse  in  1  injection pulse under test.
- expectedDelay  in  5  programmed delay; sampled on the command edge.
- measuredDelay  out  5  last measured delay, saturated to 0..31.
- pulseWidth  out  8  last measured high time in clk1280 cycles, saturating at 255.
- measValid  out  1  one-cycle strobe; measuredDelay, pulseWidth and match are valid.
- match  out  1  measuredDelay == latched expected value and no range error.
- rangeErr  out  1  raw count < OFFSET or raw - OFFSET > 31; valid with measValid.
- mismatchCount  out  CNT_W  saturating count of measurements with match=0.
- timeoutCount  out  CNT_W  saturating count of timeouts.
- spuriousCount  out  CNT_W  saturating count of pulse rising edges seen in IDLE.

Behaviour:
- Input capture: cmd and pulse each go through a 2-flop synchroniser and then a "prev" flop. Rising edge = sync & ~prev; falling edge = ~sync & prev. Both inputs share the same pipeline depth, so the capture latency cancels out of the measurement.
- Reset: asynchronous, active-low. While asserted, every output, counter and state register is 0 and the FSM is IDLE. Reset in the middle of a measurement discards it; no strobe is produced.
- FSM states: IDLE, WAIT_PULSE, MEAS_WIDTH, REPORT.
- IDLE:
  - A cmd rising edge latches expectedDelay, clears the cycle counter to 0 and moves to WAIT_PULSE.
  - A pulse rising edge with no cmd edge increments spuriousCount.
  - If both edges occur in the same cycle, the cmd edge wins and the pulse edge is not counted as spurious.
- WAIT_PULSE:
  - The counter increments every cycle.
  - On a pulse rising edge: raw = counter value in that cycle, width counter is set to 1, go to MEAS_WIDTH.
  - When the counter reaches TIMEOUT with no edge: timeoutCount++, go to IDLE. No strobe.
- MEAS_WIDTH:
  - The width counter increments each cycle while pulse stays high, saturating at 255.
  - On a pulse falling edge, go to REPORT.
  - After TIMEOUT cycles still high: timeoutCount++, go to IDLE. No strobe.
- REPORT (exactly one cycle):
  - measValid = 1.
  - measuredDelay = raw - OFFSET, clamped to 0 if raw < OFFSET and to 31 if above.
  - rangeErr and match are updated; if match = 0, mismatchCount++.
  - Next state is IDLE.
- Cmd rising edges outside IDLE are ignored and not counted. Since cmd repeats at most every 32 cycles, overlap only happens when a pulse is missing or very wide.
- Counters saturate at all-ones and never wrap.
- measuredDelay, pulseWidth, match and rangeErr hold their values between strobes. measValid is 0 except in REPORT.
- Latency: the strobe comes 1 cycle after the pulse falling edge is detected.

Decomposition:
- Shared package etroc2_ci_pkg holds:
  - the FSM state encoding (2-bit enum);
  - OFFSET and TIMEOUT default constants, shared with the pulse generator's delay definition;
  - the 5-bit delay type.
- One natural sub-module: ci_edge_sync. It contains the 2-flop synchroniser plus edge detector, produces rise and fall outputs, and is instantiated twice (cmd, pulse).
- The saturating counter is a small function in the package, not a separate module.

Test Plan:
- Reset: hold reset low 10 cycles with toggling inputs -> all outputs 0. Release -> state IDLE, no strobe.
- Delay sweep: for d = 0..31, cmd edge then pulse rising d+4 cycles later, held 16 cycles -> measuredDelay=d, pulseWidth=16, match=1, rangeErr=0, mismatchCount stays 0.
- Mismatch: expectedDelay=5, pulse arrives at raw=12 -> measuredDelay=8, match=0, mismatchCount=1.
- Range: pulse at raw=2 -> measuredDelay=0, rangeErr=1, match=0. Pulse at raw=40 -> measuredDelay=31, rangeErr=1.
- Timeout and spurious:
  - cmd with no pulse -> after 127 cycles timeoutCount=1, no measValid.
  - Pulse edge in IDLE -> spuriousCount=1.
  - Pulse held high 200 cycles -> timeoutCount increments and FSM returns to IDLE.
- Overlap and mid-op reset:
  - Second cmd edge during WAIT_PULSE is ignored, and a single strobe carries the first command's delay.
  - Reset asserted in MEAS_WIDTH -> no strobe, counters cleared.

Source files
------------

// File: rtl/etroc2_ci_pkg.sv
`default_nettype none
// Shared definitions for the charge-injection pulse generator / checker pair.
package etroc2_ci_pkg;

  localparam int unsigned CI_OFFSET  = 4;
  localparam int unsigned CI_TIMEOUT = 127;
  localparam int unsigned CI_CNT_W   = 16;

  typedef logic [4:0] ci_delay_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PULSE = 2'd1,
    ST_MEAS_WIDTH = 2'd2,
    ST_REPORT     = 2'd3
  } ci_state_e;

  // Increment that sticks at all-ones of a 'width'-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ci_edge_sync.sv
`default_nettype none
// Two-flop synchroniser followed by a one-flop edge detector.
module ci_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/charge_injection_pulse_checker.sv
`default_nettype none
// Measures command-to-pulse delay and pulse width on clk1280, compares the delay
// with the programmed value and keeps saturating mismatch/timeout/spurious counters.
module charge_injection_pulse_checker
  import etroc2_ci_pkg::*;
#(
  parameter int unsigned OFFSET  = CI_OFFSET,
  parameter int unsigned TIMEOUT = CI_TIMEOUT,
  parameter int unsigned CNT_W   = CI_CNT_W
) (
  input  logic             clk1280,
  input  logic             reset,
  input  logic             chargeInjectionCmd,
  input  logic             pulse,
  input  logic [4:0]       expectedDelay,
  output logic [4:0]       measuredDelay,
  output logic [7:0]       pulseWidth,
  output logic             measValid,
  output logic             match,
  output logic             rangeErr,
  output logic [CNT_W-1:0] mismatchCount,
  output logic [CNT_W-1:0] timeoutCount,
  output logic [CNT_W-1:0] spuriousCount
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic cmd_rise, cmd_fall_unused, pulse_rise, pulse_fall;

  ci_edge_sync u_cmd_sync (
    .clk_i  (clk1280),
    .rst_ni (reset),
    .d_i    (chargeInjectionCmd),
    .rise_o (cmd_rise),
    .fall_o (cmd_fall_unused)
  );

  ci_edge_sync u_pulse_sync (
    .clk_i  (clk1280),
    .rst_ni (reset),
    .d_i    (pulse),
    .rise_o (pulse_rise),
    .fall_o (pulse_fall)
  );

  ci_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]    raw_q, raw_d;
  logic [7:0]       width_q, width_d;
  ci_delay_t        exp_q, exp_d;
  ci_delay_t        delay_q, delay_d;
  logic [7:0]       pw_q, pw_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             range_q, range_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] spur_q, spur_d;

  logic [31:0] raw_ext;
  logic        range_low, range_high;
  ci_delay_t   delay_calc;

  assign cnt_inc    = cnt_q + 1'b1;
  assign raw_ext    = 32'(raw_q);
  assign range_low  = raw_ext < OFFSET;
  assign range_high = !range_low && ((raw_ext - OFFSET) > 32'd31);
  assign delay_calc = range_low  ? 5'd0  :
                      range_high ? 5'd31 : 5'(raw_ext - OFFSET);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    width_d = width_q;
    exp_d   = exp_q;
    delay_d = delay_q;
    pw_d    = pw_q;
    valid_d = 1'b0;
    match_d = match_q;
    range_d = range_q;
    mism_d  = mism_q;
    to_d    = to_q;
    spur_d  = spur_q;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous pulse edge belongs to the new command, not to the spurious count.
        if (cmd_rise) begin
          exp_d   = expectedDelay;
          cnt_d   = '0;
          state_d = ST_WAIT_PULSE;
        end else if (pulse_rise) begin
          spur_d = CNT_W'(sat_inc(32'(spur_q), CNT_W));
        end
      end

      ST_WAIT_PULSE: begin
        if (pulse_rise) begin
          raw_d   = cnt_inc;
          width_d = 8'd1;
          cnt_d   = '0;
          state_d = ST_MEAS_WIDTH;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          to_d    = CNT_W'(sat_inc(32'(to_q), CNT_W));
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_MEAS_WIDTH: begin
        if (pulse_fall) begin
          // Results are registered here so they are already stable while REPORT strobes.
          delay_d = delay_calc;
          pw_d    = width_q;
          range_d = range_low | range_high;
          match_d = !(range_low | range_high) && (delay_calc == exp_q);
          if ((range_low | range_high) || (delay_calc != exp_q)) begin
            mism_d = CNT_W'(sat_inc(32'(mism_q), CNT_W));
          end
          valid_d = 1'b1;
          state_d = ST_REPORT;
        end else begin
          width_d = (width_q == 8'hFF) ? width_q : width_q + 8'd1;
          if (cnt_inc == CW'(TIMEOUT)) begin
            to_d    = CNT_W'(sat_inc(32'(to_q), CNT_W));
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1280 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      raw_q   <= '0;
      width_q <= '0;
      exp_q   <= '0;
      delay_q <= '0;
      pw_q    <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      range_q <= 1'b0;
      mism_q  <= '0;
      to_q    <= '0;
      spur_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      width_q <= width_d;
      exp_q   <= exp_d;
      delay_q <= delay_d;
      pw_q    <= pw_d;
      valid_q <= valid_d;
      match_q <= match_d;
      range_q <= range_d;
      mism_q  <= mism_d;
      to_q    <= to_d;
      spur_q  <= spur_d;
    end
  end

  assign measuredDelay = delay_q;
  assign pulseWidth    = pw_q;
  assign measValid     = valid_q;
  assign match         = match_q;
  assign rangeErr      = range_q;
  assign mismatchCount = mism_q;
  assign timeoutCount  = to_q;
  assign spuriousCount = spur_q;

endmodule
`default_nettype wire
